// File: rtl/decode_pkg.sv
// Shared constants, enums and the decoded-bundle type for the RV32I decode stage.
package decode_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  localparam logic [3:0] BR_EQ  = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_LT  = 4'd2;
  localparam logic [3:0] BR_GE  = 4'd3;
  localparam logic [3:0] BR_LTU = 4'd4;
  localparam logic [3:0] BR_GEU = 4'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Everything but the immediate; the immediate width follows XLEN and travels separately.
  typedef struct packed {
    logic        reg_write;
    logic [3:0]  alucontrol;
    result_src_e result_src;
    imm_src_e    imm_src;
    logic        alu_src_imm;
    logic        is_branch_instr;
    logic        is_jump;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } decode_bundle_t;

  // ALU opcode for R/I arithmetic; alt is instr[30] already qualified by the caller.
  function automatic logic [3:0] alu_op_f(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Compare opcode for conditional branches; 010/011 are rejected elsewhere.
  function automatic logic [3:0] branch_op_f(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b001:  op = BR_NE;
      3'b100:  op = BR_LT;
      3'b101:  op = BR_GE;
      3'b110:  op = BR_LTU;
      3'b111:  op = BR_GEU;
      default: op = BR_EQ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake, flush, and the decoded bundle presented to register read.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            reg_write;
  logic [3:0]      alucontrol;
  logic [1:0]      result_src;
  logic [2:0]      imm_src;
  logic [XLEN-1:0] imm;
  logic            alu_src_imm;
  logic            is_branch_instr;
  logic            is_jump;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      mem_size;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            illegal;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, reg_write, alucontrol, result_src, imm_src, imm,
           alu_src_imm, is_branch_instr, is_jump, mem_read, mem_write, mem_size,
           rd, rs1, rs2, illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, reg_write, alucontrol, result_src, imm_src, imm,
           alu_src_imm, is_branch_instr, is_jump, mem_read, mem_write, mem_size,
           rd, rs1, rs2, illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: raw instruction word to control bundle and immediate.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output decode_bundle_t  bundle,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shamt_hi_zero;
  logic       shamt_hi_sra;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // On RV64 the shift amount grows to six bits, so only instr[31:26] is the funct field.
  assign shamt_hi_zero = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (instr[31:25] == 7'b0000000);
  assign shamt_hi_sra  = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (instr[31:25] == 7'b0100000);

  // Opcode/funct decode into control fields; illegal encodings collapse to a bare illegal flag.
  always_comb begin
    bundle            = '0;
    bundle.rd         = instr[11:7];
    bundle.rs1        = instr[19:15];
    bundle.rs2        = instr[24:20];
    bundle.alucontrol = ALU_ADD;
    bundle.result_src = RES_ALU;
    bundle.imm_src    = IMM_NONE;
    case (opcode)
      OP_R: begin
        bundle.reg_write  = 1'b1;
        bundle.alucontrol = alu_op_f(funct3, instr[30]);
        if (funct7 != 7'h00 && funct7 != 7'h20) bundle.illegal = 1'b1;
      end
      OP_IMM: begin
        bundle.reg_write   = 1'b1;
        bundle.imm_src     = IMM_I;
        bundle.alu_src_imm = 1'b1;
        bundle.alucontrol  = alu_op_f(funct3, (funct3 == 3'b101) && instr[30]);
        if (funct3 == 3'b001 && !shamt_hi_zero) bundle.illegal = 1'b1;
        if (funct3 == 3'b101 && !shamt_hi_zero && !shamt_hi_sra) bundle.illegal = 1'b1;
      end
      OP_LOAD: begin
        bundle.reg_write   = 1'b1;
        bundle.mem_read    = 1'b1;
        bundle.result_src  = RES_MEM;
        bundle.imm_src     = IMM_I;
        bundle.alu_src_imm = 1'b1;
        bundle.mem_size    = funct3;
      end
      OP_STORE: begin
        bundle.mem_write   = 1'b1;
        bundle.imm_src     = IMM_S;
        bundle.alu_src_imm = 1'b1;
        bundle.mem_size    = funct3;
      end
      OP_BRANCH: begin
        bundle.is_branch_instr = 1'b1;
        bundle.imm_src         = IMM_B;
        bundle.alucontrol      = branch_op_f(funct3);
        if (funct3 == 3'b010 || funct3 == 3'b011) bundle.illegal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        bundle.reg_write   = 1'b1;
        bundle.imm_src     = IMM_U;
        bundle.alu_src_imm = 1'b1;
      end
      OP_JAL: begin
        bundle.reg_write   = 1'b1;
        bundle.is_jump     = 1'b1;
        bundle.result_src  = RES_PC4;
        bundle.imm_src     = IMM_J;
        bundle.alu_src_imm = 1'b1;
      end
      OP_JALR: begin
        bundle.reg_write   = 1'b1;
        bundle.is_jump     = 1'b1;
        bundle.result_src  = RES_PC4;
        bundle.imm_src     = IMM_I;
        bundle.alu_src_imm = 1'b1;
      end
      default: bundle.illegal = 1'b1;
    endcase
    if (bundle.illegal) begin
      bundle         = '0;
      bundle.illegal = 1'b1;
    end
    if (!bundle.reg_write) bundle.rd = 5'd0;
  end

  // Immediate assembly and sign extension to XLEN according to the selected format.
  always_comb begin
    imm = '0;
    case (bundle.imm_src)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: optional input skid buffer, shared decoder, registered output bundle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic            out_valid_q, out_valid_d;
  decode_bundle_t  out_bundle_q, out_bundle_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  logic            load_out;
  logic            accept;
  logic [31:0]     dec_instr;
  decode_bundle_t  dec_bundle;
  logic [XLEN-1:0] dec_imm;

  // The skid entry is always older than anything on the input, so it gets the decoder first.
  assign dec_instr = skid_valid_q ? skid_instr_q : bus.in_instr;
  assign load_out  = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (SKID != 0) ? !skid_valid_q : load_out;
  assign accept    = bus.in_valid && bus.in_ready;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instr  (dec_instr),
    .bundle (dec_bundle),
    .imm    (dec_imm)
  );

  // Next-state for the output register and skid slot; flush wins over any movement.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_bundle_d = out_bundle_q;
    out_imm_d    = out_imm_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      if (skid_valid_q || accept) begin
        out_valid_d  = 1'b1;
        out_bundle_d = dec_bundle;
        out_imm_d    = dec_imm;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_instr_d = bus.in_instr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      out_imm_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_bundle_q <= out_bundle_d;
      out_imm_q    <= out_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.reg_write       = out_bundle_q.reg_write;
  assign bus.alucontrol      = out_bundle_q.alucontrol;
  assign bus.result_src      = out_bundle_q.result_src;
  assign bus.imm_src         = out_bundle_q.imm_src;
  assign bus.imm             = out_imm_q;
  assign bus.alu_src_imm     = out_bundle_q.alu_src_imm;
  assign bus.is_branch_instr = out_bundle_q.is_branch_instr;
  assign bus.is_jump         = out_bundle_q.is_jump;
  assign bus.mem_read        = out_bundle_q.mem_read;
  assign bus.mem_write       = out_bundle_q.mem_write;
  assign bus.mem_size        = out_bundle_q.mem_size;
  assign bus.rd              = out_bundle_q.rd;
  assign bus.rs1             = out_bundle_q.rs1;
  assign bus.rs2             = out_bundle_q.rs2;
  assign bus.illegal         = out_bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=32, SKID=1): FIFO-level model plus directed literals.
module tb_decode_stage;

  typedef struct packed {
    logic        reg_write;
    logic [3:0]  alu;
    logic [1:0]  res;
    logic [2:0]  isrc;
    logic [31:0] imm;
    logic        asi;
    logic        br;
    logic        jmp;
    logic        mr;
    logic        mw;
    logic [2:0]  msz;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [31:0] q[$];
  bit          model_on   = 1'b0;
  bit          after_reset = 1'b0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'hC0000093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LW   = 32'h00412283;
  localparam logic [31:0] I_AND  = 32'h0062F233;
  localparam logic [31:0] I_SRAI = 32'h40345393;
  localparam logic [31:0] I_SW   = 32'h00952623;

  logic [31:0] stim_tab [20] = '{
    32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000080E7, 32'hFE209EE3,
    32'h0020F463, 32'h0020A463, 32'h4020D1B3, 32'h0020A1B3, 32'h0020B1B3,
    32'h0020C1B3, 32'h0020E1B3, 32'h002091B3, 32'h0020D1B3, 32'hFE208FA3,
    32'hFFE09303, 32'hFFF0C293, 32'h40209093, 32'h6030D093, 32'h0000007F
  };

  decode_stage_if #(.XLEN(32)) bus_if ();

  decode_stage #(.XLEN(32), .SKID(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Expected decode derived directly from the RV32I field rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   alu_tab [8];
    int   br_tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_tab = '{0, 5, 9, 8, 4, 6, 3, 2};
    br_tab  = '{0, 1, 0, 0, 2, 3, 4, 5};
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    e = '0;
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    case (opc)
      7'h33: begin
        e.reg_write = 1'b1;
        e.alu = 4'(alu_tab[f3] + (((f3 == 3'd0 || f3 == 3'd5) && w[30]) ? 1 : 0));
        if (f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
      end
      7'h13: begin
        e.reg_write = 1'b1; e.isrc = 3'd1; e.asi = 1'b1;
        e.alu = 4'(alu_tab[f3] + ((f3 == 3'd5 && w[30]) ? 1 : 0));
        if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
      end
      7'h03: begin
        e.reg_write = 1'b1; e.mr = 1'b1; e.res = 2'd1; e.isrc = 3'd1; e.asi = 1'b1; e.msz = f3;
      end
      7'h23: begin
        e.mw = 1'b1; e.isrc = 3'd2; e.asi = 1'b1; e.msz = f3;
      end
      7'h63: begin
        e.br = 1'b1; e.isrc = 3'd3; e.alu = 4'(br_tab[f3]);
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
      end
      7'h37, 7'h17: begin
        e.reg_write = 1'b1; e.isrc = 3'd4; e.asi = 1'b1;
      end
      7'h6F: begin
        e.reg_write = 1'b1; e.jmp = 1'b1; e.res = 2'd2; e.isrc = 3'd5; e.asi = 1'b1;
      end
      7'h67: begin
        e.reg_write = 1'b1; e.jmp = 1'b1; e.res = 2'd2; e.isrc = 3'd1; e.asi = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    case (e.isrc)
      3'd1: e.imm = 32'($signed(w) >>> 20);
      3'd2: e.imm = (32'($signed(w) >>> 25) << 5) | {27'd0, w[11:7]};
      3'd3: e.imm = ({32{w[31]}} << 12) | ({31'd0, w[7]} << 11) | ({26'd0, w[30:25]} << 5) | ({28'd0, w[11:8]} << 1);
      3'd4: e.imm = w & 32'hFFFFF000;
      3'd5: e.imm = ({32{w[31]}} << 20) | ({24'd0, w[19:12]} << 12) | ({31'd0, w[20]} << 11) | ({22'd0, w[30:21]} << 1);
      default: e.imm = 32'd0;
    endcase
    if (e.ill) begin
      e = '0;
      e.ill = 1'b1;
    end
    if (!e.reg_write) e.rd = 5'd0;
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    exp_t a;
    a.reg_write = bus_if.reg_write;
    a.alu       = bus_if.alucontrol;
    a.res       = bus_if.result_src;
    a.isrc      = bus_if.imm_src;
    a.imm       = bus_if.imm;
    a.asi       = bus_if.alu_src_imm;
    a.br        = bus_if.is_branch_instr;
    a.jmp       = bus_if.is_jump;
    a.mr        = bus_if.mem_read;
    a.mw        = bus_if.mem_write;
    a.msz       = bus_if.mem_size;
    a.rd        = bus_if.rd;
    a.rs1       = bus_if.rs1;
    a.rs2       = bus_if.rs2;
    a.ill       = bus_if.illegal;
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
    bus_if.in_valid  = v;
    bus_if.in_instr  = instr;
    bus_if.out_ready = rdy;
    bus_if.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Stage contents as an ordered list of at most two accepted words.
  always @(posedge clk) begin
    bit had_valid;
    bit had_room;
    if (rst) begin
      q.delete();
      after_reset = 1'b1;
      model_on    = 1'b1;
    end else if (bus_if.flush) begin
      q.delete();
    end else begin
      had_valid = (q.size() > 0);
      had_room  = (q.size() < 2);
      if (had_valid && bus_if.out_ready) void'(q.pop_front());
      if (bus_if.in_valid && had_room) begin
        q.push_back(bus_if.in_instr);
        after_reset = 1'b0;
      end
    end
  end

  // Every-cycle comparison of handshake and bundle against the model.
  always @(negedge clk) begin
    exp_t exp_b;
    exp_t act_b;
    if (model_on) begin
      checkOutput("cyc_out_valid", {31'd0, bus_if.out_valid}, {31'd0, q.size() > 0});
      checkOutput("cyc_in_ready", {31'd0, bus_if.in_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0 || after_reset) begin
        exp_b = (q.size() > 0) ? ref_decode(q[0]) : exp_t'('0);
        act_b = dut_bundle();
        n_checks++;
        if (act_b !== exp_b) begin
          n_fails++;
          $display("[TB] FAIL cyc_bundle: got %h, expected %h", act_b, exp_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_instr  = 32'd0;
    bus_if.out_ready = 1'b1;
    bus_if.flush     = 1'b0;

    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    checkOutput("rst_imm", bus_if.imm, 32'd0);
    checkOutput("rst_alucontrol", {28'd0, bus_if.alucontrol}, 32'd0);

    $display("[TB] back-to-back add/sub");
    applyStimulus(1'b1, I_ADD, 1'b1, 1'b0);
    checkOutput("add_valid", {31'd0, bus_if.out_valid}, 32'd1);
    checkOutput("add_alu", {28'd0, bus_if.alucontrol}, 32'd0);
    checkOutput("add_rd", {27'd0, bus_if.rd}, 32'd3);
    checkOutput("add_reg_write", {31'd0, bus_if.reg_write}, 32'd1);
    applyStimulus(1'b1, I_SUB, 1'b1, 1'b0);
    checkOutput("sub_valid", {31'd0, bus_if.out_valid}, 32'd1);
    checkOutput("sub_alu", {28'd0, bus_if.alucontrol}, 32'd1);
    checkOutput("sub_rd", {27'd0, bus_if.rd}, 32'd3);

    applyStimulus(1'b1, I_ADDI, 1'b1, 1'b0);
    checkOutput("addi_alu", {28'd0, bus_if.alucontrol}, 32'd0);
    checkOutput("addi_imm", bus_if.imm, 32'hFFFFFC00);
    checkOutput("addi_alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd1);
    checkOutput("addi_imm_src", {29'd0, bus_if.imm_src}, 32'd1);

    applyStimulus(1'b1, I_BEQ, 1'b1, 1'b0);
    checkOutput("beq_branch", {31'd0, bus_if.is_branch_instr}, 32'd1);
    checkOutput("beq_alu", {28'd0, bus_if.alucontrol}, 32'd0);
    checkOutput("beq_imm", bus_if.imm, 32'd8);
    checkOutput("beq_reg_write", {31'd0, bus_if.reg_write}, 32'd0);
    checkOutput("beq_rd", {27'd0, bus_if.rd}, 32'd0);

    applyStimulus(1'b1, I_LW, 1'b1, 1'b0);
    checkOutput("lw_mem_read", {31'd0, bus_if.mem_read}, 32'd1);
    checkOutput("lw_result_src", {30'd0, bus_if.result_src}, 32'd1);
    checkOutput("lw_mem_size", {29'd0, bus_if.mem_size}, 32'd2);
    checkOutput("lw_imm", bus_if.imm, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    $display("[TB] stall with skid buffer");
    applyStimulus(1'b1, I_AND, 1'b0, 1'b0);
    checkOutput("stall1_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    applyStimulus(1'b1, I_SRAI, 1'b0, 1'b0);
    checkOutput("stall2_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    checkOutput("stall2_alu_held", {28'd0, bus_if.alucontrol}, 32'd2);
    applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
    checkOutput("stall3_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    checkOutput("stall3_rd_held", {27'd0, bus_if.rd}, 32'd4);
    applyStimulus(1'b1, I_SW, 1'b1, 1'b0);
    checkOutput("drain1_alu", {28'd0, bus_if.alucontrol}, 32'd7);
    checkOutput("drain1_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    applyStimulus(1'b1, I_SW, 1'b1, 1'b0);
    checkOutput("drain2_mem_write", {31'd0, bus_if.mem_write}, 32'd1);
    checkOutput("drain2_imm", bus_if.imm, 32'd12);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("drain3_out_valid", {31'd0, bus_if.out_valid}, 32'd0);

    $display("[TB] flush with full stage");
    applyStimulus(1'b1, I_AND, 1'b0, 1'b0);
    applyStimulus(1'b1, I_SRAI, 1'b0, 1'b0);
    applyStimulus(1'b1, I_SW, 1'b0, 1'b1);
    checkOutput("flush_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush_after_valid", {31'd0, bus_if.out_valid}, 32'd0);
    applyStimulus(1'b1, I_ADD, 1'b1, 1'b1);
    checkOutput("flush_drop_valid", {31'd0, bus_if.out_valid}, 32'd0);

    $display("[TB] illegal encodings");
    applyStimulus(1'b1, 32'h00000000, 1'b1, 1'b0);
    checkOutput("ill0_illegal", {31'd0, bus_if.illegal}, 32'd1);
    checkOutput("ill0_valid", {31'd0, bus_if.out_valid}, 32'd1);
    checkOutput("ill0_flags", {27'd0, bus_if.reg_write, bus_if.mem_read, bus_if.mem_write,
                               bus_if.is_branch_instr, bus_if.is_jump}, 32'd0);
    applyStimulus(1'b1, 32'h022081B3, 1'b1, 1'b0);
    checkOutput("illmul_illegal", {31'd0, bus_if.illegal}, 32'd1);
    checkOutput("illmul_flags", {27'd0, bus_if.reg_write, bus_if.mem_read, bus_if.mem_write,
                                 bus_if.is_branch_instr, bus_if.is_jump}, 32'd0);

    $display("[TB] mixed stream");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, stim_tab[i], (i % 3) != 2, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, I_AND, 1'b0, 1'b0);
    applyStimulus(1'b1, I_SRAI, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    checkOutput("mrst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    checkOutput("mrst_imm", bus_if.imm, 32'd0);
    checkOutput("mrst_rd", {27'd0, bus_if.rd}, 32'd0);
    applyStimulus(1'b1, I_BEQ, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
